uart_loopback_fifo: RTL and testbench
=====================================

UART_LOOPBACK_FIFO -- requirements
Module: uart_loopback_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the FIFO depth in bytes (power of two, 4..64).
REQ-002 SHALL have parameter AW, default 4, the pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port rx_data, input, 8 bits: received byte from the upstream receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe; rx_data is valid while it is high.
REQ-007 SHALL have port tx_done, input, 1 bit: the downstream transmitter has finished the current byte.
REQ-008 SHALL have port tx_data, output, 8 bits: byte presented to the transmitter (registered).
REQ-009 SHALL have port tx_en, output, 1 bit: one-cycle start strobe to the transmitter (registered).
REQ-010 SHALL have port count, output, AW+1 bits: current FIFO occupancy, 0..DEPTH.
REQ-011 SHALL have port empty, output, 1 bit: high when count==0.
REQ-012 SHALL have port full, output, 1 bit: high when count==DEPTH.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag meaning a byte was dropped.

Function
REQ-014 SHALL implement a circular buffer of DEPTH x 8 bits with write pointer wp and read pointer rp, each AW bits; both wrap from DEPTH-1 to 0 naturally.
REQ-015 SHALL push only when, at a clock edge, rx_valid=1 and full=0: mem[wp]<=rx_data, wp increments.
REQ-016 SHALL, when rx_valid=1 and full=1, drop the byte, leave wp unchanged, and set overflow to 1 until reset; this applies even if a pop occurs in the same cycle (no pass-through when full).
REQ-017 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop; count never exceeds DEPTH or goes below 0.
REQ-018 SHALL derive empty and full combinationally from count.
REQ-019 SHALL implement a transmit FSM with states IDLE, LAUNCH and WAIT.
REQ-020 SHALL, in IDLE with empty=0, pop: tx_data<=mem[rp], rp increments, next state LAUNCH; with empty=1, stay in IDLE.
REQ-021 SHALL assert tx_en=1 for exactly the one cycle spent in LAUNCH, with next state WAIT unconditionally.
REQ-022 SHALL, in WAIT, return to IDLE on the first edge with tx_done=1; tx_done seen in IDLE or LAUNCH is ignored.
REQ-023 SHALL hold tx_data stable from the pop edge until the next pop.
REQ-024 SHALL give a latency, into an empty FIFO with the FSM in IDLE, of: push at edge N, pop at edge N+1, tx_en high between edges N+1 and N+2.
REQ-025 SHALL allow a push in the same cycle as a pop, including a push into the slot being freed, as long as full=0 before the edge.
REQ-026 SHALL allow back-to-back bytes: after tx_done, IDLE pops on the next edge if empty=0, giving a 3-cycle minimum spacing between tx_en pulses.
REQ-027 SHALL never emit tx_en while the FSM is in WAIT or IDLE.

Reset
REQ-028 SHALL, when rst=0 at a clock edge, clear wp, rp, count, tx_data (8'h00), tx_en (0) and overflow (0), and put the FSM in IDLE; as a result empty=1 and full=0.
REQ-029 SHALL give reset priority over all events, including mid-transmission (WAIT); no tx_en follows the reset edge, and buffered bytes are discarded.
REQ-030 SHALL NOT require memory contents to be reset.

Verification
REQ-031 SHALL pass this scenario: single byte 8'hA5 pushed at edge N, tx_done held low -> tx_data=8'hA5 after edge N+1, tx_en high for exactly one cycle after edge N+1, count returns to 0, and the FSM waits indefinitely in WAIT.
REQ-032 SHALL pass this scenario: bytes 8'h01..8'h05 pushed on consecutive cycles, tx_done pulsed 10 cycles after each tx_en -> five tx_en pulses carrying 8'h01..8'h05 in order, no pulse before its tx_done, and overflow=0.
REQ-033 SHALL pass this scenario: tx_done held low and 17 pushes with DEPTH=16 -> 1 popped, 16 stored, full=1, count=16; an 18th push -> overflow=1 and count stays 16.
REQ-034 SHALL pass this scenario: FIFO full and a push in the same cycle as a tx_done-triggered pop -> the push is dropped, overflow=1, count=15 after the pop.
REQ-035 SHALL pass this scenario: wrap-around, with 40 bytes streamed continuously and a tx_done response of 3 cycles -> output order matches input and count never exceeds 16.
REQ-036 SHALL pass this scenario: rst=0 asserted for one cycle while in WAIT with count=3 -> count=0, empty=1, tx_en=0 and overflow=0 next cycle, and a new push after release transmits normally.

Source files
------------

// File: rtl/uart_loopback_fifo.sv
// -----------------------------------------------------------------------------
// uart_loopback_fifo
//
// Buffers bytes arriving from a UART receiver in a DEPTH x 8 circular buffer
// and feeds them one at a time to a UART transmitter.
//
// Handshake semantics (the only ones used in this block):
//   rx_valid is a one-cycle strobe. A byte is accepted on the edge where
//   rx_valid=1 and full=0; with full=1 it is dropped and overflow latches.
//   tx_en is a one-cycle start strobe that carries tx_data. The next byte is
//   not launched until the transmitter answers with tx_done while the FSM is
//   in WAIT; tx_done at any other time is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   rx_data    received byte            rx_valid  strobe for rx_data
//   tx_done    transmitter finished the current byte
//   tx_data    byte to transmit (registered, stable between pops)
//   tx_en      one-cycle transmit start strobe (registered)
//   count      occupancy 0..DEPTH       empty/full  derived from count
//   overflow   sticky: a byte was dropped since reset
//   dbg_state  transmit FSM state (0=IDLE, 1=LAUNCH, 2=WAIT)
// -----------------------------------------------------------------------------
module uart_loopback_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          tx_done,
  output logic [7:0]    tx_data,
  output logic          tx_en,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic [7:0]    r_tx_data;
  logic          r_tx_en;
  logic          r_overflow;
  state_t        r_state;

  state_t        w_next_state;
  logic          w_pop;
  logic          w_push;
  logic          w_empty;
  logic          w_full;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == L_DEPTH);
  // A push is judged against full before the edge, so a pop in the same
  // cycle never makes room for a byte arriving while full.
  assign w_push  = rx_valid && !w_full;

  // Transmit FSM: next-state and pop decision.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = LAUNCH;
        end
      end
      LAUNCH: w_next_state = WAIT;
      WAIT: begin
        if (tx_done) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_en    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp      <= r_rp + 1'b1;
        r_tx_data <= r_mem[r_rp];
      end
      // The strobe rises together with the entry into LAUNCH.
      r_tx_en <= w_pop;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (rx_valid && w_full) r_overflow <= 1'b1;
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_en     = r_tx_en;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_loopback_fifo
//
// Directed stimulus for uart_loopback_fifo. Bytes expected on the transmit
// side are queued in exp_q when they are issued; a monitor pops and compares
// on every tx_en. A responder process is the only driver of tx_done: it
// either answers each tx_en after done_delay cycles or emits a single pulse
// when the main sequence bumps req_cnt.
// -----------------------------------------------------------------------------
module tb_uart_loopback_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          tx_done;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic [1:0]    dbg_state;

  int            errors;
  int            checks;
  logic [7:0]    exp_q[$];
  int            rst_cnt;
  int            req_cnt;
  int            done_delay;
  int            phase;
  int            max_cnt_t5;

  uart_loopback_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_done   (tx_done),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- responder (sole driver of tx_done) ----------------
  initial begin : responder
    int seen_req;
    int timer;
    seen_req = 0;
    timer    = 0;
    tx_done  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_done = 1'b0;
      if (!rst) timer = 0;
      else if (tx_en && done_delay > 0) timer = done_delay;
      else if (timer > 0) begin
        timer--;
        if (timer == 0) tx_done = 1'b1;
      end
      if (seen_req != req_cnt) begin
        seen_req = req_cnt;
        tx_done  = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int         seen_rst;
    bit         need_done;
    logic [7:0] e;
    seen_rst   = 0;
    need_done  = 1'b0;
    max_cnt_t5 = 0;
    forever begin
      @(negedge clk);
      if (seen_rst != rst_cnt) begin
        seen_rst  = rst_cnt;
        need_done = 1'b0;
      end
      if (phase == 5 && int'(count) > max_cnt_t5) max_cnt_t5 = int'(count);
      if (tx_en) begin
        check("tx_en_only_in_launch", int'(dbg_state), int'(S_LAUNCH));
        check("tx_en_after_tx_done", int'(need_done), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_en: got data 0x%0h, expected no transmission", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data_order", int'(tx_data), int'(e));
        end
        need_done = 1'b1;
      end else if (tx_done && dbg_state == S_WAIT) begin
        need_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    rx_data  = d;
    rx_valid = 1'b1;
    if (accept) exp_q.push_back(d);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rst_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && dbg_state == S_IDLE && count == '0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: timeout with %0d bytes outstanding, count=%0d, expected all transmitted",
               name, exp_q.size(), count);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    errors     = 0;
    checks     = 0;
    rst_cnt    = 0;
    req_cnt    = 0;
    done_delay = 0;
    phase      = 0;
    rst        = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_tx_en", int'(tx_en), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_state", int'(dbg_state), int'(S_IDLE));
    step();

    // Single byte, no tx_done: latency, LAUNCH ignores tx_done, WAIT holds
    phase = 1;
    push(8'hA5, 1'b1);
    @(negedge clk);
    check("t1_count_after_push", int'(count), 1);
    check("t1_no_early_tx_en", int'(tx_en), 0);
    step();
    req_cnt++;
    @(negedge clk);
    check("t1_tx_en_latency", int'(tx_en), 1);
    check("t1_tx_data", int'(tx_data), 8'hA5);
    check("t1_count_after_pop", int'(count), 0);
    step();
    @(negedge clk);
    check("t1_tx_en_one_cycle", int'(tx_en), 0);
    check("t1_state_wait", int'(dbg_state), int'(S_WAIT));
    repeat (6) step();
    @(negedge clk);
    check("t1_waits_indefinitely", int'(dbg_state), int'(S_WAIT));
    check("t1_tx_data_held", int'(tx_data), 8'hA5);
    step();
    do_reset();
    @(negedge clk);
    check("t1_reset_to_idle", int'(dbg_state), int'(S_IDLE));
    step();

    // Five bytes back to back, tx_done 10 cycles after each tx_en
    phase      = 2;
    done_delay = 10;
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    drain(400, "t2_drain");
    check("t2_overflow", int'(overflow), 0);

    // Fill: 17 pushes with tx_done low, then one more dropped
    phase      = 3;
    done_delay = 0;
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), 1'b1);
    @(negedge clk);
    check("t3_full", int'(full), 1);
    check("t3_count16", int'(count), 16);
    check("t3_no_overflow_yet", int'(overflow), 0);
    step();
    push(8'hEE, 1'b0);
    @(negedge clk);
    check("t3_overflow_set", int'(overflow), 1);
    check("t3_count_stays16", int'(count), 16);
    step();
    do_reset();
    @(negedge clk);
    check("t3_reset_clears_overflow", int'(overflow), 0);
    check("t3_reset_clears_count", int'(count), 0);
    step();
    for (int i = 0; i < 17; i++) push(8'h30 + 8'(i), 1'b1);
    @(negedge clk);
    check("t4_refill_count16", int'(count), 16);
    step();

    // Full FIFO: push coincides with the pop that follows tx_done
    phase = 4;
    req_cnt++;
    step();
    done_delay = 3;
    push(8'hEF, 1'b0);
    @(negedge clk);
    check("t4_count15", int'(count), 15);
    check("t4_overflow", int'(overflow), 1);
    check("t4_not_full", int'(full), 0);
    step();
    drain(1000, "t4_drain");

    // Wrap-around stream, 3-cycle tx_done response
    phase = 5;
    for (int i = 0; i < 40; i++) begin
      push(8'(i * 7 + 3), 1'b1);
      repeat (3) step();
    end
    drain(1500, "t5_drain");
    check("t5_count_le_depth", (max_cnt_t5 <= DEPTH) ? 1 : 0, 1);
    check("t5_overflow_sticky", int'(overflow), 1);

    // Reset while in WAIT with three bytes buffered
    phase      = 6;
    done_delay = 0;
    for (int i = 0; i < 4; i++) push(8'h51 + 8'(i), 1'b1);
    @(negedge clk);
    check("t6_count3", int'(count), 3);
    check("t6_in_wait", int'(dbg_state), int'(S_WAIT));
    step();
    do_reset();
    @(negedge clk);
    check("t6_count0", int'(count), 0);
    check("t6_empty", int'(empty), 1);
    check("t6_tx_en", int'(tx_en), 0);
    check("t6_overflow", int'(overflow), 0);
    check("t6_idle", int'(dbg_state), int'(S_IDLE));
    step();
    done_delay = 3;
    push(8'h3C, 1'b1);
    drain(100, "t6_after_reset");

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
